// File: rtl/clk_strobe_gen_if.sv
// Bus bundle for clk_strobe_gen: control inputs and per-channel strobe outputs.
// master drives the controls (consumer side); slave is the generator.
interface clk_strobe_gen_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 20
);
   localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en;
   logic              sync_clr;
   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_wdata;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] tick_dly;
   logic [NUM_CH-1:0] sq_out;
   logic [NUM_CH-1:0] pending;

   modport master (
      output en, sync_clr, div_wr, div_sel, div_wdata,
      input  tick, tick_dly, sq_out, pending
   );

   modport slave (
      input  en, sync_clr, div_wr, div_sel, div_wdata,
      output tick, tick_dly, sq_out, pending
   );
endinterface

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable generator. Each channel counts to a runtime divisor N and
// emits a one-cycle tick, a toggling square level and (optionally) a delayed tick.
// Divisor writes go to a shadow register and take effect at the next wrap so the running
// period is never cut short; idle or halted channels take them immediately.
// Optional feature macro: CLK_STROBE_GEN_DLY_TICK_EN builds the tick_dly flops; without it
// tick_dly is tied low and the port is kept.
module clk_strobe_gen #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 20,
   parameter int unsigned DIV_INIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   clk_strobe_gen_if.slave bus
);

   logic [NUM_CH-1:0][CNT_W-1:0] cntQ, cntD;
   logic [NUM_CH-1:0][CNT_W-1:0] divActQ, divActD;
   logic [NUM_CH-1:0][CNT_W-1:0] divShdQ, divShdD;
   logic [NUM_CH-1:0]            tickQ, tickD;
   logic [NUM_CH-1:0]            sqQ, sqD;
   logic [NUM_CH-1:0]            pendQ, pendD;

   logic [NUM_CH-1:0]            wrSel;
   logic [NUM_CH-1:0]            run;
   logic [NUM_CH-1:0]            wrap;

   // Per-channel decode of the write strobe and the run/wrap conditions.
   always_comb begin
      wrSel = '0;
      run   = '0;
      wrap  = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         // Out-of-range selects match no channel and are dropped.
         wrSel[i] = bus.div_wr && (int'(bus.div_sel) == i);
         run[i]   = bus.en[i] && (divActQ[i] != '0);
         // >= rather than == keeps a stale count from running past a shortened divisor.
         wrap[i]  = run[i] && (cntQ[i] >= divActQ[i] - CNT_W'(1));
      end
   end

   // Next-state for counters, strobes and the shadow/active divisor pair.
   always_comb begin
      cntD    = cntQ;
      divActD = divActQ;
      divShdD = divShdQ;
      tickD   = '0;
      sqD     = sqQ;
      pendD   = pendQ;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (wrSel[i]) begin
            divShdD[i] = bus.div_wdata;
         end
         if (bus.sync_clr) begin
            cntD[i] = '0;
            sqD[i]  = 1'b0;
            // Same-cycle write wins over an older pending shadow.
            if (wrSel[i]) begin
               divActD[i] = bus.div_wdata;
            end else if (pendQ[i]) begin
               divActD[i] = divShdQ[i];
            end
            pendD[i] = 1'b0;
         end else begin
            if (!run[i]) begin
               if (divActQ[i] == '0) begin
                  cntD[i] = '0;
               end
            end else if (wrap[i]) begin
               cntD[i]  = '0;
               tickD[i] = 1'b1;
               sqD[i]   = ~sqQ[i];
            end else begin
               cntD[i] = cntQ[i] + CNT_W'(1);
            end

            // No period in flight (idle/halted) or one ending now: apply at once.
            if (wrSel[i]) begin
               if (!run[i] || wrap[i]) begin
                  divActD[i] = bus.div_wdata;
                  pendD[i]   = 1'b0;
               end else begin
                  pendD[i] = 1'b1;
               end
            end else if (pendQ[i] && (!bus.en[i] || wrap[i])) begin
               divActD[i] = divShdQ[i];
               pendD[i]   = 1'b0;
            end
         end
      end
   end

   // Channel state registers; programmed divisors fall back to DIV_INIT on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntQ    <= '0;
         divActQ <= {NUM_CH{CNT_W'(DIV_INIT)}};
         divShdQ <= {NUM_CH{CNT_W'(DIV_INIT)}};
         tickQ   <= '0;
         sqQ     <= '0;
         pendQ   <= '0;
      end else begin
         cntQ    <= cntD;
         divActQ <= divActD;
         divShdQ <= divShdD;
         tickQ   <= tickD;
         sqQ     <= sqD;
         pendQ   <= pendD;
      end
   end

`ifdef CLK_STROBE_GEN_DLY_TICK_EN
   logic [NUM_CH-1:0] tickDlyQ;

   // Delayed strobe follows tick unconditionally; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tickDlyQ <= '0;
      end else begin
         tickDlyQ <= tickQ;
      end
   end

   assign bus.tick_dly = tickDlyQ;
`else
   assign bus.tick_dly = '0;
`endif

   assign bus.tick    = tickQ;
   assign bus.sq_out  = sqQ;
   assign bus.pending = pendQ;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed bench for clk_strobe_gen: 4-channel main instance plus a 3-channel instance
// whose 2-bit select can address a non-existent channel.
module tb_clk_strobe_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   clk_strobe_gen_if #(.NUM_CH(4), .CNT_W(20)) bus ();
   clk_strobe_gen_if #(.NUM_CH(3), .CNT_W(8))  bus3 ();

   clk_strobe_gen #(.NUM_CH(4), .CNT_W(20), .DIV_INIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   clk_strobe_gen #(.NUM_CH(3), .CNT_W(8), .DIV_INIT(4)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.en        = '0;
      bus.sync_clr  = 1'b0;
      bus.div_wr    = 1'b0;
      bus.div_sel   = '0;
      bus.div_wdata = '0;
      bus3.en        = '0;
      bus3.sync_clr  = 1'b0;
      bus3.div_wr    = 1'b0;
      bus3.div_sel   = '0;
      bus3.div_wdata = '0;
   endtask

   // Returns just after an edge with reset released; the next step() is edge 1.
   task automatic do_reset(input logic [3:0] enVal);
      step();
      rst_n = 1'b0;
      clear_inputs();
      step();
      step();
      rst_n   = 1'b1;
      bus.en  = enVal;
      bus3.en = enVal[2:0];
   endtask

   task automatic write(input int sel, input int data);
      bus.div_wr    = 1'b1;
      bus.div_sel   = 2'(sel);
      bus.div_wdata = 20'(data);
      step();
      bus.div_wr = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] expTick, expSq, expDly, prevTick;
      rst_n = 1'b1;
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      vecs += 4;
      if (bus.tick !== 4'h0) begin
         errs++; $display("FAIL reset_tick: got %h want 0", bus.tick);
      end
      if (bus.sq_out !== 4'h0) begin
         errs++; $display("FAIL reset_sq: got %h want 0", bus.sq_out);
      end
      if (bus.pending !== 4'h0) begin
         errs++; $display("FAIL reset_pending: got %h want 0", bus.pending);
      end
      if (bus.tick_dly !== 4'h0) begin
         errs++; $display("FAIL reset_dly: got %h want 0", bus.tick_dly);
      end
      step();
      step();
      rst_n  = 1'b1;
      bus.en = 4'hF;
      prevTick = 4'h0;
      for (int k = 1; k <= 13; k++) begin
         step();
         expTick = (k % 4 == 0) ? 4'hF : 4'h0;
         expSq   = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
`ifdef CLK_STROBE_GEN_DLY_TICK_EN
         expDly = prevTick;
`else
         expDly = 4'h0;
`endif
         vecs += 3;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL run_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
         if (bus.sq_out !== expSq) begin
            errs++; $display("FAIL run_sq edge %0d: got %h want %h", k, bus.sq_out, expSq);
         end
         if (bus.tick_dly !== expDly) begin
            errs++; $display("FAIL run_dly edge %0d: got %h want %h", k, bus.tick_dly, expDly);
         end
         prevTick = expTick;
      end
   endtask

   task automatic test_shadow();
      logic [3:0] expTick, expPend;
      do_reset(4'hF);
      step();
      write(1, 3);
      vecs++;
      if (bus.pending !== 4'b0010) begin
         errs++; $display("FAIL shadow_pending_set: got %h want 2", bus.pending);
      end
      for (int k = 3; k <= 13; k++) begin
         step();
         expTick    = (k % 4 == 0) ? 4'b1101 : 4'b0000;
         expTick[1] = (k >= 4) && ((k - 4) % 3 == 0);
         expPend    = (k < 4) ? 4'b0010 : 4'b0000;
         vecs += 2;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL shadow_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
         if (bus.pending !== expPend) begin
            errs++; $display("FAIL shadow_pend edge %0d: got %h want %h", k, bus.pending, expPend);
         end
      end
   endtask

   task automatic test_halt();
      logic [3:0] expTick;
      do_reset(4'hF);
      step();
      write(2, 0);
      vecs++;
      if (bus.pending !== 4'b0100) begin
         errs++; $display("FAIL halt_pending: got %h want 4", bus.pending);
      end
      for (int k = 3; k <= 12; k++) begin
         step();
         expTick    = (k % 4 == 0) ? 4'b1011 : 4'b0000;
         expTick[2] = (k == 4);
         vecs++;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL halt_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
      end
      write(2, 2);
      vecs += 2;
      if (bus.tick !== 4'h0) begin
         errs++; $display("FAIL restart_tick edge 13: got %h want 0", bus.tick);
      end
      if (bus.pending !== 4'h0) begin
         errs++; $display("FAIL restart_pending: got %h want 0", bus.pending);
      end
      for (int k = 14; k <= 20; k++) begin
         step();
         expTick    = (k % 4 == 0) ? 4'b1011 : 4'b0000;
         expTick[2] = (k >= 15) && ((k - 15) % 2 == 0);
         vecs++;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL restart_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
      end
   endtask

   task automatic test_sync_clr();
      logic [3:0] expTick, expSq;
      int         div [4];
      do_reset(4'h0);
      write(1, 5);
      write(2, 6);
      bus.en = 4'hF;
      for (int k = 0; k < 7; k++) step();
      // Clear together with a fresh write to ch3: it must take effect at the clear.
      bus.sync_clr  = 1'b1;
      bus.div_wr    = 1'b1;
      bus.div_sel   = 2'd3;
      bus.div_wdata = 20'd3;
      step();
      bus.sync_clr = 1'b0;
      bus.div_wr   = 1'b0;
      vecs += 3;
      if (bus.tick !== 4'h0) begin
         errs++; $display("FAIL clr_tick: got %h want 0", bus.tick);
      end
      if (bus.sq_out !== 4'h0) begin
         errs++; $display("FAIL clr_sq: got %h want 0", bus.sq_out);
      end
      if (bus.pending !== 4'h0) begin
         errs++; $display("FAIL clr_pending: got %h want 0", bus.pending);
      end
      div[0] = 4; div[1] = 5; div[2] = 6; div[3] = 3;
      for (int k = 1; k <= 12; k++) begin
         step();
         for (int c = 0; c < 4; c++) begin
            expTick[c] = (k % div[c] == 0);
            expSq[c]   = ((k / div[c]) % 2 == 1);
         end
         vecs += 2;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL clr_run_tick +%0d: got %h want %h", k, bus.tick, expTick);
         end
         if (bus.sq_out !== expSq) begin
            errs++; $display("FAIL clr_run_sq +%0d: got %h want %h", k, bus.sq_out, expSq);
         end
      end
   endtask

   task automatic test_enable();
      logic [3:0] expTick, expSq;
      do_reset(4'hF);
      step();
      step();
      bus.en = 4'hE;
      for (int k = 3; k <= 12; k++) begin
         step();
         expTick    = (k % 4 == 0) ? 4'b1110 : 4'b0000;
         expTick[0] = (k == 11);
         expSq      = ((k / 4) % 2 == 1) ? 4'b1110 : 4'b0000;
         expSq[0]   = (k >= 11);
         vecs += 2;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL en_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
         if (bus.sq_out !== expSq) begin
            errs++; $display("FAIL en_sq edge %0d: got %h want %h", k, bus.sq_out, expSq);
         end
         if (k == 9) bus.en = 4'hF;
      end
   endtask

   task automatic test_div_one();
      logic [3:0] expSq;
      do_reset(4'h0);
      write(3, 1);
      bus.en = 4'h8;
      for (int k = 1; k <= 4; k++) begin
         step();
         expSq = (k % 2 == 1) ? 4'h8 : 4'h0;
         vecs += 2;
         if (bus.tick !== 4'h8) begin
            errs++; $display("FAIL div1_tick edge %0d: got %h want 8", k, bus.tick);
         end
         if (bus.sq_out !== expSq) begin
            errs++; $display("FAIL div1_sq edge %0d: got %h want %h", k, bus.sq_out, expSq);
         end
      end
   endtask

   task automatic test_oob();
      logic [2:0] expTick;
      do_reset(4'h7);
      step();
      bus3.div_wr    = 1'b1;
      bus3.div_sel   = 2'd3;
      bus3.div_wdata = 8'd2;
      step();
      bus3.div_wr = 1'b0;
      vecs++;
      if (bus3.pending !== 3'b000) begin
         errs++; $display("FAIL oob_pending: got %h want 0", bus3.pending);
      end
      for (int k = 3; k <= 9; k++) begin
         step();
         expTick = (k % 4 == 0) ? 3'b111 : 3'b000;
         vecs += 2;
         if (bus3.tick !== expTick) begin
            errs++; $display("FAIL oob_tick edge %0d: got %h want %h", k, bus3.tick, expTick);
         end
         if (bus3.pending !== 3'b000) begin
            errs++; $display("FAIL oob_pend edge %0d: got %h want 0", k, bus3.pending);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] expTick;
      do_reset(4'h0);
      write(0, 7);
      bus.en = 4'hF;
      for (int k = 1; k <= 4; k++) step();
      vecs++;
      if (bus.tick !== 4'hE) begin
         errs++; $display("FAIL pre_rst_tick: got %h want e", bus.tick);
      end
      #2 rst_n = 1'b0;
      #1;
      vecs += 3;
      if (bus.tick !== 4'h0) begin
         errs++; $display("FAIL async_rst_tick: got %h want 0", bus.tick);
      end
      if (bus.sq_out !== 4'h0) begin
         errs++; $display("FAIL async_rst_sq: got %h want 0", bus.sq_out);
      end
      if (bus.tick_dly !== 4'h0) begin
         errs++; $display("FAIL async_rst_dly: got %h want 0", bus.tick_dly);
      end
      step();
      rst_n  = 1'b1;
      bus.en = 4'hF;
      for (int k = 1; k <= 4; k++) begin
         step();
         expTick = (k == 4) ? 4'hF : 4'h0;
         vecs++;
         if (bus.tick !== expTick) begin
            errs++; $display("FAIL post_rst_tick edge %0d: got %h want %h", k, bus.tick, expTick);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shadow();
      test_halt();
      test_sync_clr();
      test_enable();
      test_div_one();
      test_oob();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
